// File: rtl/hpi_seq.sv
// hpi_seq: hardware sequencer for the CY7C67200 HPI software-side port (address write + data burst).
// Define HPI_SEQ_WDATA_TIMEOUT_EN to abort write bursts whose data stalls for TIMEOUT_CYCLES.
module hpi_seq #(
  parameter int unsigned STROBE_CYCLES  = 2,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [15:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        done,
  output logic        err,
  output logic [1:0]  hpi_address,
  output logic [15:0] hpi_data_out,
  input  logic [15:0] hpi_data_in,
  output logic        hpi_r_n,
  output logic        hpi_w_n,
  output logic        hpi_cs_n
);
  localparam int unsigned MaxPhase = (STROBE_CYCLES > RECOVER_CYCLES) ? STROBE_CYCLES
                                                                      : RECOVER_CYCLES;
  localparam int unsigned CntW = $clog2(MaxPhase + 1);
  localparam logic [CntW-1:0] StrbLast = CntW'(STROBE_CYCLES - 1);
  localparam logic [CntW-1:0] RecLast  = CntW'(RECOVER_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StAddrStrb, StAddrRec, StWaitWdata, StDataStrb, StDataRec, StDone
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      word_q, len_q;
  logic            write_q;
  logic            r_n_q, w_n_q, cs_n_q;
  logic [1:0]      addr_q;
  logic [15:0]     dout_q, rdata_q;
  logic            rvalid_q, done_q;

`ifdef HPI_SEQ_WDATA_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  logic [TmoW-1:0] tmo_q;
  logic            err_q;
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  assign req_ready    = (state_q == StIdle);
  assign wdata_ready  = (state_q == StWaitWdata);
  assign rdata        = rdata_q;
  assign rdata_valid  = rvalid_q;
  assign done         = done_q;
  assign hpi_address  = addr_q;
  assign hpi_data_out = dout_q;
  assign hpi_r_n      = r_n_q;
  assign hpi_w_n      = w_n_q;
  assign hpi_cs_n     = cs_n_q;

  // Strobe outputs are registered, so each state's strobe levels are set on the edge entering it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      word_q   <= '0;
      len_q    <= '0;
      write_q  <= 1'b0;
      r_n_q    <= 1'b1;
      w_n_q    <= 1'b1;
      cs_n_q   <= 1'b1;
      addr_q   <= 2'd0;
      dout_q   <= 16'h0000;
      rdata_q  <= 16'h0000;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef HPI_SEQ_WDATA_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef HPI_SEQ_WDATA_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q <= req_write;
            len_q   <= req_len;
            word_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= 2'd2;
            dout_q  <= req_addr;
            cs_n_q  <= 1'b0;
            w_n_q   <= 1'b0;
            state_q <= StAddrStrb;
          end
        end
        StAddrStrb, StDataStrb: begin
          if (cnt_q == StrbLast) begin
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            w_n_q   <= 1'b1;
            r_n_q   <= 1'b1;
            state_q <= (state_q == StAddrStrb) ? StAddrRec : StDataRec;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StAddrRec, StDataRec: begin
          // Interface adds two cycles of latency, so read data is present on the first recovery cycle.
          if (state_q == StDataRec && !write_q && cnt_q == '0) begin
            rdata_q  <= hpi_data_in;
            rvalid_q <= 1'b1;
          end
          if (cnt_q != RecLast) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (state_q == StDataRec && word_q == len_q) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= '0;
            if (state_q == StDataRec) word_q <= word_q + 1'b1;
            if (write_q) begin
`ifdef HPI_SEQ_WDATA_TIMEOUT_EN
              tmo_q <= '0;
`endif
              state_q <= StWaitWdata;
            end else begin
              addr_q  <= 2'd0;
              cs_n_q  <= 1'b0;
              r_n_q   <= 1'b0;
              state_q <= StDataStrb;
            end
          end
        end
        StWaitWdata: begin
          if (wdata_valid) begin
            dout_q  <= wdata;
            addr_q  <= 2'd0;
            cs_n_q  <= 1'b0;
            w_n_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= StDataStrb;
`ifdef HPI_SEQ_WDATA_TIMEOUT_EN
          end else if (tmo_q == TmoLast) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= StDone;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
